// File: rtl/memarb_pkg.sv
// memarb_pkg: shared types for the unified memory port arbiter.
//   arb_state_t : FSM encoding (IDLE / GRANT / WAIT / RESP)
//   req_id_t    : requester ids (REQ_IF = 0, REQ_DM = 1)
//   cnt_w()     : latency down-counter width for a given MEM_LAT
package memarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int MEM_LAT_MAX = 15;

  // Counter holds MEM_LAT-1 at most; keep at least one bit so MEM_LAT=1 still elaborates.
  function automatic int cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/memarb_pick.sv
// memarb_pick: combinational winner selector.
//   if_req, dm_req : live requests
//   last           : requester granted most recently (round-robin build only)
//   win            : selected requester id (only meaningful when a request is up)
// MEMARB_RR_EN defined   -> conflicts go to whoever was not granted last.
// MEMARB_RR_EN undefined -> DM always wins a conflict.
module memarb_pick
  import memarb_pkg::*;
(
  input  logic    if_req,
  input  logic    dm_req,
  input  req_id_t last,
  output req_id_t win
);

`ifdef MEMARB_RR_EN
  always_comb begin
    win = dm_req ? REQ_DM : REQ_IF;
    if (if_req && dm_req) win = (last == REQ_DM) ? REQ_IF : REQ_DM;
  end
`else
  // Fixed priority needs neither the IF request nor the history.
  logic [1:0] unused_in;
  assign unused_in = {if_req, last};
  assign win       = dm_req ? REQ_DM : REQ_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch (IF)
// and data (DM). One transaction in flight; requests sampled in IDLE or RESP.
// Ports:
//   clk, reset                       clock, async active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata      fetch side
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_gnt/dm_rvalid/dm_rdata   data side
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be, mem_rdata   memory macro side
//   busy                             high whenever the FSM is not IDLE
// Build option: MEMARB_RR_EN selects round-robin instead of DM-first priority.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = cnt_w(MEM_LAT);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } acc_t;

  arb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  req_id_t       win, win_n, pick_id, last;
  acc_t          acc, acc_n;

  memarb_pick u_pick (
    .if_req (if_req),
    .dm_req (dm_req),
    .last   (last),
    .win    (pick_id)
  );

`ifdef MEMARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  last <= REQ_IF;
    else if (state_n == ST_GRANT) last <= win_n;
  end
`else
  assign last = REQ_IF;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    win_n   = win;
    acc_n   = acc;
    unique case (state)
      // RESP doubles as a sample slot so a held request goes straight back to GRANT.
      ST_IDLE, ST_RESP: begin
        state_n = ST_IDLE;
        if (if_req || dm_req) begin
          state_n = ST_GRANT;
          win_n   = pick_id;
          if (pick_id == REQ_DM)
            acc_n = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
          else
            acc_n = '{we: 1'b0, addr: if_addr, wdata: '0, be: '1};
        end
      end
      ST_GRANT: begin
        cnt_n   = CW'(MEM_LAT - 1);
        state_n = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt <= CW'(1)) state_n = ST_RESP;
        else               cnt_n   = cnt - CW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are flops, not gates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      win       <= REQ_IF;
      acc       <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      win       <= win_n;
      acc       <= acc_n;
      if_gnt    <= (state_n == ST_GRANT) && (win_n == REQ_IF);
      dm_gnt    <= (state_n == ST_GRANT) && (win_n == REQ_DM);
      if_rvalid <= (state_n == ST_RESP)  && (win_n == REQ_IF);
      dm_rvalid <= (state_n == ST_RESP)  && (win_n == REQ_DM);
      mem_en    <= (state_n == ST_GRANT);
      busy      <= (state_n != ST_IDLE);
    end
  end

  assign mem_we    = acc.we;
  assign mem_addr  = acc.addr;
  assign mem_wdata = acc.wdata;
  assign mem_be    = acc.be;

  // acc still describes the finishing transaction during RESP, so a write reports zero data.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign dm_rdata = (dm_rvalid && !acc.we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int L  = 2;
  localparam int NR = 600;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req, dm_req, dm_we, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] dm_wdata, mem_rdata, if_rdata, dm_rdata, mem_wdata;
  logic [BW-1:0] dm_be, mem_be;

  logic          if_req1, dm_req1, dm_we1, if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, mem_we1, busy1;
  logic [AW-1:0] if_addr1, dm_addr1, mem_addr1;
  logic [DW-1:0] dm_wdata1, if_rdata1, dm_rdata1, mem_wdata1;
  logic [BW-1:0] dm_be1, mem_be1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_be(dm_be1),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_be(mem_be1),
    .mem_rdata(mem_rdata), .busy(busy1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // eg/erv are {dm,if}; rdw marks the DM transaction finishing this cycle as a write.
  task automatic chk_out(input string tag, input logic [1:0] eg, input logic [1:0] erv, input logic eb,
                         input logic [31:0] ea, input logic ew, input logic rdw);
    logic [31:0] e_ifd, e_dmd;
    e_ifd = erv[0] ? mem_rdata : 32'h0;
    e_dmd = (erv[1] && !rdw) ? mem_rdata : 32'h0;
    check({tag, ".gnt"},      64'({dm_gnt, if_gnt}),       64'(eg));
    check({tag, ".rvalid"},   64'({dm_rvalid, if_rvalid}), 64'(erv));
    check({tag, ".busy"},     64'(busy),                   64'(eb));
    check({tag, ".mem_en"},   64'(mem_en),                 64'(|eg));
    if (|eg) begin
      check({tag, ".mem_addr"}, 64'(mem_addr), 64'(ea));
      check({tag, ".mem_we"},   64'(mem_we),   64'(ew));
    end
    check({tag, ".if_rdata"}, 64'(if_rdata), 64'(e_ifd));
    check({tag, ".dm_rdata"}, 64'(dm_rdata), 64'(e_dmd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        busy;
    logic [31:0] maddr;
    logic        mwe;
  } vec_t;

  function automatic vec_t mk(input int ir, input logic [31:0] ia, input int dr, input int dw,
                              input logic [31:0] da, input logic [31:0] dwd, input int g,
                              input int rv, input int b, input logic [31:0] ma, input int mw);
    vec_t v;
    v.if_req = 1'(ir); v.if_addr = ia; v.dm_req = 1'(dr); v.dm_we = 1'(dw);
    v.dm_addr = da; v.dm_wdata = dwd; v.gnt = 2'(g); v.rv = 2'(rv);
    v.busy = 1'(b); v.maddr = ma; v.mwe = 1'(mw);
    return v;
  endfunction

  vec_t tbl[18];

  // Random-phase expectations, indexed by cycle.
  logic [1:0]  e_gnt[NR+8];
  logic [1:0]  e_rv[NR+8];
  logic        e_busy[NR+8];
  logic [31:0] e_addr[NR+8];
  logic        e_we[NR+8];
  logic [31:0] e_wd[NR+8];
  logic [3:0]  e_be[NR+8];
  logic        e_rdwe[NR+8];

  initial begin
    logic       tbl_wr;
    logic [1:0] eg, erv;
    int         ord[4];
    int         ns;
    logic       m_last_dm, w_dm, if_seen, dm_seen;

    reset = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = '0; dm_wdata1 = '0; dm_be1 = '0;
    mem_rdata = 32'hA5A5_1234;

    // Conflict first so the round-robin history is "IF last" afterwards in both builds.
    tbl[0]  = mk(1, 32'h40, 1, 0, 32'h300, 32'h0,        0, 0, 0, 32'h0,   0);
    tbl[1]  = mk(1, 32'h40, 1, 0, 32'h300, 32'h0,        2, 0, 1, 32'h300, 0);
    tbl[2]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 0, 1, 32'h0,   0);
    tbl[3]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 2, 1, 32'h0,   0);
    tbl[4]  = mk(1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'h40,  0);
    tbl[5]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 1, 32'h0,   0);
    tbl[6]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,   0);
    tbl[7]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   0);
    tbl[8]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   0);
    tbl[9]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'h10,  0);
    tbl[10] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 1, 32'h0,   0);
    tbl[11] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 1, 32'h0,   0);
    tbl[12] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   0);
    tbl[13] = mk(0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 0, 0, 0, 32'h0,   0);
    tbl[14] = mk(0, 32'h0,  1, 1, 32'h200, 32'hDEADBEEF, 2, 0, 1, 32'h200, 1);
    tbl[15] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 1, 32'h0,   0);
    tbl[16] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 2, 1, 32'h0,   0);
    tbl[17] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 32'h0,   0);

    // Reset state
    step(); step();
    @(negedge clk);
    chk_out("reset", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    check("reset.mem_addr", 64'(mem_addr), 64'h0);
    check("reset.busy1",    64'(busy1),    64'h0);
    step();
    reset = 1'b0;

    // Table: conflict, lone fetch, DM write
    tbl_wr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
      dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr;
      dm_wdata = tbl[i].dm_wdata; dm_be = 4'hF;
      mem_rdata = $urandom;
      @(negedge clk);
      if (tbl[i].gnt[1]) tbl_wr = tbl[i].mwe;
      chk_out($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].rv, tbl[i].busy, tbl[i].maddr, tbl[i].mwe, tbl_wr);
      if (tbl[i].gnt[1] && tbl[i].mwe) begin
        check($sformatf("tbl[%0d].mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].dm_wdata));
        check($sformatf("tbl[%0d].mem_be", i),    64'(mem_be),    64'h0F);
      end
    end

    // Back-to-back fetches: gnt at 1,4,7 and rvalid at 3,6,9
    for (int c = 0; c < 12; c++) begin
      step();
      if_req = (c < 8); if_addr = 32'h80; dm_req = 1'b0; dm_we = 1'b0;
      mem_rdata = $urandom;
      @(negedge clk);
      eg  = (c == 1 || c == 4 || c == 7) ? 2'b01 : 2'b00;
      erv = (c == 3 || c == 6 || c == 9) ? 2'b01 : 2'b00;
      chk_out($sformatf("b2b[%0d]", c), eg, erv, (c >= 1 && c <= 9), 32'h80, 1'b0, 1'b0);
    end

    // Both held: grant order depends on the arbitration policy; DM drops after its 3rd slot
`ifdef MEMARB_RR_EN
    ord = '{2, 1, 2, 1};
`else
    ord = '{2, 2, 2, 1};
`endif
    for (int c = 0; c < 15; c++) begin
      step();
      if_req = (c < 11); if_addr = 32'h44;
      dm_req = (c < 8);  dm_we = 1'b0; dm_addr = 32'h330;
      mem_rdata = $urandom;
      @(negedge clk);
      eg = 2'b00; erv = 2'b00;
      for (int k = 0; k < 4; k++) begin
        if (c == 1 + 3 * k) eg  = 2'(ord[k]);
        if (c == 3 + 3 * k) erv = 2'(ord[k]);
      end
      chk_out($sformatf("both[%0d]", c), eg, erv, (c >= 1 && c <= 12),
              (eg == 2'b10) ? 32'h330 : 32'h44, 1'b0, 1'b0);
    end

    // Reset during WAIT: outputs clear at once, the pending response never shows
    step(); if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b0;
    @(negedge clk);
    chk_out("rst.c0", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk_out("rst.c1", 2'b01, 2'b00, 1'b1, 32'h44, 1'b0, 1'b0);
    step(); if_req = 1'b0; mem_rdata = 32'h1357_9BDF;
    #2; reset = 1'b1; #1;
    check("rst.async.gnt",      64'({dm_gnt, if_gnt}),       64'h0);
    check("rst.async.rvalid",   64'({dm_rvalid, if_rvalid}), 64'h0);
    check("rst.async.busy",     64'(busy),                   64'h0);
    check("rst.async.mem_en",   64'(mem_en),                 64'h0);
    check("rst.async.mem_addr", 64'(mem_addr),               64'h0);
    check("rst.async.if_rdata", 64'(if_rdata),               64'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(); mem_rdata = $urandom;
      @(negedge clk);
      chk_out($sformatf("rst.post[%0d]", c), 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    step(); if_req = 1'b1; if_addr = 32'h48;
    @(negedge clk);
    chk_out("rst.m0", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk_out("rst.m1", 2'b01, 2'b00, 1'b1, 32'h48, 1'b0, 1'b0);
    step(); if_req = 1'b0;
    @(negedge clk);
    chk_out("rst.m2", 2'b00, 2'b00, 1'b1, 32'h0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk_out("rst.m3", 2'b00, 2'b01, 1'b1, 32'h0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    chk_out("rst.m4", 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);

    // MEM_LAT=1 instance: gnt at N+1, rvalid at N+2, idle at N+3
    step(); dm_req1 = 1'b1; dm_we1 = 1'b0; dm_addr1 = 32'h20; dm_be1 = 4'hF;
    @(negedge clk);
    check("lat1.c0.gnt",  64'({dm_gnt1, if_gnt1}), 64'h0);
    check("lat1.c0.busy", 64'(busy1),              64'h0);
    step(); mem_rdata = $urandom;
    @(negedge clk);
    check("lat1.c1.gnt",      64'({dm_gnt1, if_gnt1}),       64'h2);
    check("lat1.c1.mem_en",   64'(mem_en1),                  64'h1);
    check("lat1.c1.mem_addr", 64'(mem_addr1),                64'h20);
    check("lat1.c1.rvalid",   64'({dm_rvalid1, if_rvalid1}), 64'h0);
    step(); dm_req1 = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    check("lat1.c2.rvalid",   64'({dm_rvalid1, if_rvalid1}), 64'h2);
    check("lat1.c2.dm_rdata", 64'(dm_rdata1),                64'(mem_rdata));
    check("lat1.c2.busy",     64'(busy1),                    64'h1);
    step();
    @(negedge clk);
    check("lat1.c3.rvalid", 64'({dm_rvalid1, if_rvalid1}), 64'h0);
    check("lat1.c3.busy",   64'(busy1),                    64'h0);

    // Random traffic against a timestamp model: a sample at cycle t grants at t+1,
    // completes at t+1+L, and the completion cycle is the next sample slot.
    for (int i = 0; i < NR + 8; i++) begin
      e_gnt[i] = 2'b00; e_rv[i] = 2'b00; e_busy[i] = 1'b0; e_addr[i] = '0;
      e_we[i] = 1'b0; e_wd[i] = '0; e_be[i] = '0; e_rdwe[i] = 1'b0;
    end
    ns = 0; m_last_dm = 1'b0; if_seen = 1'b0; dm_seen = 1'b0;
    for (int c = 0; c < NR; c++) begin
      step();
      mem_rdata = $urandom;
      if (if_req && if_seen) begin
        if ($urandom_range(1) == 1) if_addr = $urandom; else if_req = 1'b0;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (dm_req && dm_seen) begin
        if ($urandom_range(1) == 1) begin
          dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
        end else dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
      end
      @(negedge clk);
      chk_out($sformatf("rand[%0d]", c), e_gnt[c], e_rv[c], e_busy[c], e_addr[c], e_we[c], e_rdwe[c]);
      if (e_gnt[c] == 2'b10 && e_we[c]) begin
        check($sformatf("rand[%0d].mem_wdata", c), 64'(mem_wdata), 64'(e_wd[c]));
        check($sformatf("rand[%0d].mem_be", c),    64'(mem_be),    64'(e_be[c]));
      end
      if_seen = if_gnt; dm_seen = dm_gnt;
      if (c >= ns) begin
        if (if_req || dm_req) begin
          if (if_req && dm_req) begin
`ifdef MEMARB_RR_EN
            w_dm = !m_last_dm;
`else
            w_dm = 1'b1;
`endif
          end else w_dm = dm_req;
          m_last_dm = w_dm;
          e_gnt[c + 1]  = w_dm ? 2'b10 : 2'b01;
          e_addr[c + 1] = w_dm ? dm_addr : if_addr;
          e_we[c + 1]   = w_dm && dm_we;
          e_wd[c + 1]   = dm_wdata;
          e_be[c + 1]   = dm_be;
          e_rv[c + 1 + L]   = w_dm ? 2'b10 : 2'b01;
          e_rdwe[c + 1 + L] = w_dm && dm_we;
          for (int k = c + 1; k <= c + 1 + L; k++) e_busy[k] = 1'b1;
          ns = c + 1 + L;
        end else begin
          ns = c + 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
